// File: rtl/ipv_stream_scheduler_if.sv
// Signal bundle between the IPV bit requesters, the shared popcount reducer and the VOV consumer.
// slave = the scheduler; master = everything around it.
interface ipv_stream_scheduler_if #(
    parameter int N = 4
) ();
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   src_bit;
    logic [N-1:0]   src_valid;
    logic [N-1:0]   gnt;
    logic           red_ipv;
    logic           red_valid;
    logic [3:0]     red_vov;
    logic           res_valid;
    logic [IDW-1:0] res_id;
    logic [3:0]     res_data;
    logic           res_err;
    logic           busy;

    modport slave (
        input  req, src_bit, src_valid, red_vov,
        output gnt, red_ipv, red_valid, res_valid, res_id, res_data, res_err, busy
    );

    modport master (
        output req, src_bit, src_valid, red_vov,
        input  gnt, red_ipv, red_valid, res_valid, res_id, res_data, res_err, busy
    );
endinterface

// File: rtl/ipv_stream_scheduler.sv
// Round-robin scheduler sharing one K-bit IPV popcount reducer between N lanes, with id/err tag realignment.
// Optional idle-lane timeout padding: define IPVS_TIMEOUT_EN.
module ipv_stream_scheduler #(
    parameter int N         = 4,
    parameter int K         = 4,
    parameter int RED_LAT   = 5,
    parameter int TO_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ipv_stream_scheduler_if.slave bus
);
    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(K + 1);

    typedef enum logic {IDLE, STREAM} state_t;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
        logic           err;
    } tag_t;

    state_t         state;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] pick;
    logic [CW-1:0]  bit_cnt;
    tag_t           tag_pipe [RED_LAT];
    logic           tag_busy;
    logic           valid_in;
    logic           bit_in;
    logic           acc;
    logic           last;
    logic           tag_err;
    logic           pad;

    // Requester closest to rr_ptr in circular order wins.
    always_comb begin
        int best;
        best = N;
        pick = '0;
        for (int j = 0; j < N; j++) begin
            if (bus.req[j] && ((j + N - int'(rr_ptr)) % N) < best) begin
                best = (j + N - int'(rr_ptr)) % N;
                pick = IDW'(j);
            end
        end
    end

    always_comb begin
        valid_in = bus.src_valid[sel];
        bit_in   = bus.src_bit[sel];
        if (pad) begin
            valid_in = 1'b1;
            bit_in   = 1'b0;
        end
        acc = (state == STREAM) && valid_in;
    end

    assign last          = acc && (bit_cnt == CW'(K - 1));
    assign bus.red_valid = acc;
    assign bus.red_ipv   = acc & bit_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bus.gnt <= '0;
            sel     <= '0;
            rr_ptr  <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        bus.gnt <= N'(1) << pick;
                        sel     <= pick;
                        bit_cnt <= '0;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (acc && bit_cnt != CW'(K))
                        bit_cnt <= bit_cnt + 1'b1;
                    // Dropping gnt here leaves exactly one bubble cycle in IDLE before the next group.
                    if (last) begin
                        bus.gnt <= '0;
                        rr_ptr  <= (sel == IDW'(N - 1)) ? '0 : sel + 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IPVS_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);

    logic [TW-1:0] idle_cnt;

    // Once padding starts the lane is ignored until the group completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            pad      <= 1'b0;
        end else if (state != STREAM) begin
            idle_cnt <= '0;
            pad      <= 1'b0;
        end else if (!pad) begin
            if (bus.src_valid[sel])
                idle_cnt <= '0;
            else if (idle_cnt == TW'(TO_CYCLES - 1))
                pad <= 1'b1;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign tag_err = pad;
`else
    logic unused_ok;

    assign pad         = 1'b0;
    assign tag_err     = 1'b0;
    assign bus.res_err = 1'b0;
    assign unused_ok   = (TO_CYCLES > 0) ^ tag_pipe[RED_LAT-1].err;
`endif

    // Tag leaves the pipe in the same cycle the reducer presents that group's count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RED_LAT; i++)
                tag_pipe[i] <= '0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= '0;
            bus.res_data  <= '0;
`ifdef IPVS_TIMEOUT_EN
            bus.res_err   <= 1'b0;
`endif
        end else begin
            tag_pipe[0] <= tag_t'({last, sel, tag_err});
            for (int i = 1; i < RED_LAT; i++)
                tag_pipe[i] <= tag_pipe[i-1];
            bus.res_valid <= tag_pipe[RED_LAT-1].vld;
            if (tag_pipe[RED_LAT-1].vld) begin
                bus.res_id   <= tag_pipe[RED_LAT-1].id;
                bus.res_data <= bus.red_vov;
`ifdef IPVS_TIMEOUT_EN
                bus.res_err  <= tag_pipe[RED_LAT-1].err;
`endif
            end
        end
    end

    always_comb begin
        tag_busy = 1'b0;
        for (int i = 0; i < RED_LAT; i++)
            tag_busy |= tag_pipe[i].vld;
    end

    assign bus.busy = (state == STREAM) | tag_busy;
endmodule

// File: tb/tb_ipv_stream_scheduler.sv
// Bench for ipv_stream_scheduler: directed tables, hand sequences, and random traffic against a transaction model.
module tb_ipv_stream_scheduler;
    localparam int N = 4, K = 4, RED_LAT = 5, TO_CYCLES = 16, K8 = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ipv_stream_scheduler_if #(.N(N)) bus ();
    ipv_stream_scheduler_if #(.N(N)) bus8 ();

    ipv_stream_scheduler #(.N(N), .K(K), .RED_LAT(RED_LAT), .TO_CYCLES(TO_CYCLES)) u_dut (
        .clk(clk), .rst(rst), .bus(bus));
    ipv_stream_scheduler #(.N(N), .K(K8), .RED_LAT(RED_LAT), .TO_CYCLES(TO_CYCLES)) u_dut8 (
        .clk(clk), .rst(rst), .bus(bus8));

    // Reducer stand-ins: popcount of each K-bit group, shown RED_LAT cycles after its last bit, 4'hF otherwise.
    int         ra, rn, ra8, rn8;
    logic [3:0] rd  [RED_LAT];
    logic [3:0] rd8 [RED_LAT];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ra <= 0; rn <= 0; ra8 <= 0; rn8 <= 0;
            for (int i = 0; i < RED_LAT; i++) begin rd[i] <= 4'hF; rd8[i] <= 4'hF; end
        end else begin
            for (int i = 1; i < RED_LAT; i++) begin rd[i] <= rd[i-1]; rd8[i] <= rd8[i-1]; end
            rd[0]  <= 4'hF;
            rd8[0] <= 4'hF;
            if (bus.red_valid) begin
                if (rn == K - 1) begin rd[0] <= 4'(ra + int'(bus.red_ipv)); rn <= 0; ra <= 0; end
                else begin rn <= rn + 1; ra <= ra + int'(bus.red_ipv); end
            end
            if (bus8.red_valid) begin
                if (rn8 == K8 - 1) begin rd8[0] <= 4'(ra8 + int'(bus8.red_ipv)); rn8 <= 0; ra8 <= 0; end
                else begin rn8 <= rn8 + 1; ra8 <= ra8 + int'(bus8.red_ipv); end
            end
        end
    end
    assign bus.red_vov  = rd[RED_LAT-1];
    assign bus8.red_vov = rd8[RED_LAT-1];

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [N-1:0] rq, sv, sb, gnt;
        logic         rv, ri, rs;
        int           id, dat;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] rq, sv, sb, g, input logic rv, ri, rs,
                                input int id, dat);
        vec_t v;
        v.rq = rq; v.sv = sv; v.sb = sb; v.gnt = g; v.rv = rv; v.ri = ri; v.rs = rs;
        v.id = id; v.dat = dat;
        return v;
    endfunction

    // Transaction model: current grant, bits so far, and results queued with the cycle they are due.
    typedef struct { int id; int dat; int due; } res_t;
    res_t         expq[$];
    bit           m_on;
    int           m_lane, m_cnt, m_ones, m_rr, cyc;
    logic [N-1:0] pend;

    task automatic step(input logic [N-1:0] rq, sv, sb);
        logic [N-1:0] eg;
        logic         erv, eri, ers, eb;
        bus.req = rq; bus.src_valid = sv; bus.src_bit = sb;
        #1;
        eg  = m_on ? (N'(1) << m_lane) : '0;
        erv = m_on && sv[m_lane];
        eri = erv && sb[m_lane];
        ers = expq.size() > 0 && expq[0].due == cyc;
        eb  = m_on;
        foreach (expq[i]) if (expq[i].due > cyc) eb = 1'b1;
        chk("gnt", bus.gnt, eg);
        chk("red_valid", bus.red_valid, erv);
        chk("red_ipv", bus.red_ipv, eri);
        chk("res_valid", bus.res_valid, ers);
        chk("busy", bus.busy, eb);
        if (ers) begin
            chk("res_id", bus.res_id, expq[0].id);
            chk("res_data", bus.res_data, expq[0].dat);
            chk("res_err", bus.res_err, 0);
            void'(expq.pop_front());
        end
        if (m_on) begin
            if (sv[m_lane]) begin m_cnt++; m_ones += int'(sb[m_lane]); end
            if (m_cnt == K) begin
                expq.push_back('{m_lane, m_ones, cyc + RED_LAT + 1});
                m_on = 0;
                pend[m_lane] = 1'b0;
                m_rr = (m_lane + 1) % N;
            end
        end else if (rq != '0) begin
            for (int i = 0; i < N; i++)
                if (!m_on && rq[(m_rr + i) % N]) begin
                    m_lane = (m_rr + i) % N; m_on = 1; m_cnt = 0; m_ones = 0;
                end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        bus.req = '0; bus.src_valid = '0; bus.src_bit = '0;
        for (int c = 0; c < cycles; c++) begin
            #1;
            chk("rst_gnt", bus.gnt, 0);
            chk("rst_red_valid", bus.red_valid, 0);
            chk("rst_red_ipv", bus.red_ipv, 0);
            chk("rst_res_valid", bus.res_valid, 0);
            chk("rst_res_id", bus.res_id, 0);
            chk("rst_res_data", bus.res_data, 0);
            chk("rst_res_err", bus.res_err, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_busy8", bus8.busy, 0);
            @(negedge clk);
        end
        rst = 1'b0;
        expq.delete();
        m_on = 0; m_rr = 0; cyc = 0;
    endtask

    vec_t tbl[$];
    int   n8;
    int   r8c [4];
    int   r8d [4];

    initial begin
        bus.req = '0; bus.src_valid = '0; bus.src_bit = '0;
        bus8.req = '0; bus8.src_valid = '0; bus8.src_bit = '0;
        pend = '0;

        // Lane 2 sends 1,0,1,1; other lanes' valids must be ignored.
        tbl.push_back(mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0100, 4'b1111, 4'b0100, 4'b0100, 1, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0100, 4'b1111, 4'b1011, 4'b0100, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0100, 4'b0100, 4'b0100, 4'b0100, 1, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0100, 4'b0100, 4'b0100, 4'b0100, 1, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0, 0, 0));
        repeat (4) tbl.push_back(mk('0, '0, '0, '0, 0, 0, 0, 0, 0));
        tbl.push_back(mk('0, '0, '0, '0, 0, 0, 1, 2, 3));
        tbl.push_back(mk('0, '0, '0, '0, 0, 0, 0, 0, 0));
        // Lane 1 gapped: 1,(3 gaps),1,0,(1 gap),1.
        tbl.push_back(mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0010, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0, 0, 0));
        repeat (3) tbl.push_back(mk(4'b0010, 4'b1101, 4'b1111, 4'b0010, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0010, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0010, 4'b0000, 4'b0010, 4'b0010, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0010, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0, 0, 0));
        repeat (4) tbl.push_back(mk('0, '0, '0, '0, 0, 0, 0, 0, 0));
        tbl.push_back(mk('0, '0, '0, '0, 0, 0, 1, 1, 3));
        tbl.push_back(mk('0, '0, '0, '0, 0, 0, 0, 0, 0));

        @(negedge clk);
        do_reset(2);

        foreach (tbl[i]) begin
            bus.req = tbl[i].rq; bus.src_valid = tbl[i].sv; bus.src_bit = tbl[i].sb;
            #1;
            chk($sformatf("t%0d_gnt", i), bus.gnt, tbl[i].gnt);
            chk($sformatf("t%0d_red_valid", i), bus.red_valid, tbl[i].rv);
            chk($sformatf("t%0d_red_ipv", i), bus.red_ipv, tbl[i].ri);
            chk($sformatf("t%0d_res_valid", i), bus.res_valid, tbl[i].rs);
            if (tbl[i].rs) begin
                chk($sformatf("t%0d_res_id", i), bus.res_id, tbl[i].id);
                chk($sformatf("t%0d_res_data", i), bus.res_data, tbl[i].dat);
                chk($sformatf("t%0d_res_err", i), bus.res_err, 0);
            end
            @(negedge clk);
        end

        // All lanes requesting, all ones: grant order 0,1,2,3,... every K+1 cycles.
        do_reset(2);
        for (int c = 0; c < 30; c++) step('1, '1, '1);

        // Random requests and bits.
        pend = '1;
        for (int c = 0; c < 400; c++) begin
            for (int l = 0; l < N; l++)
                if (!pend[l] && $urandom_range(3) == 0) pend[l] = 1'b1;
            step(pend, N'($urandom), N'($urandom));
        end
        for (int c = 0; c < 40; c++)
            step(m_on ? (N'(1) << m_lane) : '0, '1, N'($urandom));

        // Reset while groups are outstanding: they must never report.
        for (int c = 0; c < 30 && expq.size() < 2; c++) step('1, '1, '1);
        do_reset(2);
        for (int c = 0; c < 5; c++) step(4'b0001, '1, N'($urandom));
        for (int c = 0; c < 12; c++) step('0, '0, '0);

        // K=8 lane 0: all ones then all zeros.
        n8 = 0;
        for (int c = 0; c < 30; c++) begin
            bus8.req       = (c <= 17) ? 4'b0001 : 4'b0000;
            bus8.src_valid = '1;
            bus8.src_bit   = (c <= 8) ? '1 : '0;
            #1;
            if (c == 9)  chk("k8_gnt_bubble", bus8.gnt, 4'b0000);
            if (c == 10) chk("k8_gnt_regrant", bus8.gnt, 4'b0001);
            if (bus8.res_valid) begin
                if (n8 < 4) begin r8c[n8] = c; r8d[n8] = int'(bus8.res_data); end
                n8++;
            end
            @(negedge clk);
        end
        chk("k8_results", n8, 2);
        if (n8 >= 2) begin
            chk("k8_first_cycle", r8c[0], 14);
            chk("k8_first_data", r8d[0], 8);
            chk("k8_second_data", r8d[1], 0);
            chk("k8_spacing", r8c[1] - r8c[0], 9);
        end

`ifdef IPVS_TIMEOUT_EN
        // Lane 1 sends 1,1 then stalls; two zero bits are padded after TO_CYCLES idle cycles.
        do_reset(2);
        for (int c = 0; c < 28; c++) begin
            bus.req       = (c <= 20) ? 4'b0010 : 4'b0100;
            bus.src_valid = (c == 1 || c == 2) ? 4'b0010 : 4'b1101;
            bus.src_bit   = '1;
            #1;
            if (c == 18) chk("to_idle_valid", bus.red_valid, 0);
            if (c == 19 || c == 20) begin
                chk("to_pad_valid", bus.red_valid, 1);
                chk("to_pad_bit", bus.red_ipv, 0);
            end
            if (c == 21) chk("to_gnt_drop", bus.gnt, 4'b0000);
            if (c == 22) chk("to_next_gnt", bus.gnt, 4'b0100);
            if (c == 25) chk("to_res_early", bus.res_valid, 0);
            if (c == 26) begin
                chk("to_res_valid", bus.res_valid, 1);
                chk("to_res_id", bus.res_id, 1);
                chk("to_res_data", bus.res_data, 2);
                chk("to_res_err", bus.res_err, 1);
            end
            @(negedge clk);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ipv_stream_scheduler.md
# ipv_stream_scheduler

Round-robin scheduler that shares one `IPV_reducer` instance (K-bit popcount reducer) between N requesters. Each requester streams a group of K serial IPV bits. The block grants one requester at a time and forwards its bits to the reducer. It tags each group with the requester's lane id and realigns the reducer's fixed-latency count output with that tag. It sits between the per-channel IPV bit generators and the downstream VOV consumer.

## Interface
Parameters:
- `N`, 4, number of requesters (2..8)
- `K`, 4, bits per group; must equal the reducer's k (2..8)
- `RED_LAT`, 5, cycles from the cycle the K-th bit is presented to the reducer until its count is on `red_vov`
- `TO_CYCLES`, 16, idle-bit timeout length (used only with `IPVS_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  N  per-lane request; held high until its grant drops
- `src_bit`  in  N  per-lane IPV bit
- `src_valid`  in  N  per-lane bit valid; a bit is accepted only while that lane is granted
- `gnt`  out  N  one-hot grant, registered
- `red_ipv`  out  1  to reducer `ipv_in`
- `red_valid`  out  1  to reducer `in_valid`
- `red_vov`  in  4  from reducer `vov`
- `res_valid`  out  1  result strobe, one cycle per group
- `res_id`  out  `$clog2(N)`  lane id of the result
- `res_data`  out  4  popcount of the group (0..K)
- `res_err`  out  1  group was padded by a timeout; constant 0 without the macro
- `busy`  out  1  high in STREAM or while any tag is in flight

## Operation
- FSM has two states: IDLE and STREAM. Reset state is IDLE.
- IDLE: if `req != 0`, the round-robin arbiter picks the first requesting lane at or after `rr_ptr`. The FSM registers `gnt` one-hot, loads `sel`, clears `bit_cnt` and goes to STREAM. If no lane requests, it stays in IDLE with `gnt = 0`.
- STREAM:
  - `red_valid = src_valid[sel]` and `red_ipv = src_bit[sel]`, both combinational.
  - `bit_cnt` increments on each accepted bit.
  - On the K-th accepted bit:
    - push tag {`sel`, err} into the tag pipeline;
    - `rr_ptr <= sel+1 mod N`;
    - clear `gnt` at the next edge;
    - return to IDLE.
- This gives exactly one bubble cycle between groups. A lane with `req` still high re-arbitrates against the others.
- Outside STREAM, `red_valid = 0` and `red_ipv = 0`, so the reducer is never fed a partial group.
- Tag pipeline: RED_LAT-deep shift register of {valid, id, err} that advances every cycle.
  - When the tag reaches the end, register `res_valid = 1`, `res_id` and `res_err`, and capture `res_data = red_vov` in the same cycle.
  - Several groups may be in flight at once; the results emerge in grant order.
- `req` deasserted mid-STREAM is a protocol violation; the grant is held until K bits are accepted.
- `src_valid` on non-granted lanes is ignored.

## Timing
- Reset values: `gnt = 0`, `red_valid = 0`, `red_ipv = 0`, `res_valid = 0`, `res_id = 0`, `res_data = 0`, `res_err = 0`, `busy = 0`, `rr_ptr = 0`, all tags invalid, `bit_cnt = 0`.
- `req` seen in cycle c in IDLE gives `gnt` high from cycle c+1; the first bit can be accepted in c+1.
- K-th bit accepted in cycle t:
  - `gnt` is low from cycle t+1;
  - `red_vov` is sampled in cycle t+RED_LAT;
  - `res_valid` is high in cycle t+RED_LAT+1 for exactly one cycle.
- Minimum group period is K+1 cycles (K bits plus one bubble).
- `bit_cnt` width is `$clog2(K+1)` and saturates at K. `res_data` is 4 bits; K=8 all-ones gives 8.
- Reset mid-operation: all state clears immediately and in-flight tags are discarded, so no `res_valid` is produced for them. The reducer must share `rst` through an inverter to its `rst_n` so both reset together.

## Configuration
- `IPVS_TIMEOUT_EN` defined:
  - In STREAM, an idle counter counts consecutive cycles with `src_valid[sel] = 0`.
  - At `TO_CYCLES`, the block pads the rest of the group with `red_valid = 1`, `red_ipv = 0`, one bit per cycle, and ignores the lane.
  - The group's tag has err=1, and the group completes as normal.
- `IPVS_TIMEOUT_EN` not defined:
  - No idle counter; STREAM waits indefinitely.
  - `res_err` is tied to 0.

## Test plan
- Single lane, K=4: lane 2 sends 1,0,1,1 back-to-back after its grant -> one `res_valid` with `res_id = 2`, `res_data = 3`, `res_err = 0`, exactly RED_LAT+1 cycles after the 4th bit.
- All four `req` high from reset, each lane sends all ones -> `gnt` order 0,1,2,3,0,…, group period 5 cycles, results in the same order with `res_data = 4`.
- Gapped stream: lane 1 sends 1,(gap 3 cycles),1,0,(gap 1),1 -> `res_data = 3`, `red_valid` low during the gaps, no extra results.
- K=8, one lane all ones then all zeros -> `res_data = 8`, then `res_data = 0`; the second result arrives 9 cycles after the first.
- With `IPVS_TIMEOUT_EN` and `TO_CYCLES = 16`: lane 1 sends 1,1 then stalls -> after 16 idle cycles, 2 zero bits are padded; `res_data = 2`, `res_err = 1`; next arbitration is normal.
- Assert `rst` for 2 cycles mid-STREAM with 2 tags in flight -> outputs at reset values, no `res_valid`; the next group from lane 0 gives the correct count.
